// File: rtl/uart_display_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_display_ctrl_pkg
// Shared encodings for the UART display feeder: display mode, baud-select codes,
// byte direction, FSM states and the packed {dir,byte} event entry.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_display_ctrl_pkg;

    // Display stage mode select
    localparam logic BAUDRATE_MODE = 1'b0;
    localparam logic DATA_MODE     = 1'b1;

    // Baud-select switch codes (2'b11 is illegal and passed through untouched)
    localparam logic [1:0] SEL_9600   = 2'b00;
    localparam logic [1:0] SEL_57600  = 2'b01;
    localparam logic [1:0] SEL_115200 = 2'b10;

    // Direction of a displayed byte
    localparam logic DIR_RX = 1'b0;
    localparam logic DIR_TX = 1'b1;

    // Width of one queued event: {dir, byte}
    localparam int EVENT_W = 9;

    typedef enum logic [1:0] {
        S_BAUD = 2'b00,
        S_LOAD = 2'b01,
        S_DATA = 2'b10
    } disp_state_e;

    // Build a queue entry from a direction bit and a byte
    function automatic logic [EVENT_W-1:0] pack_event(input logic dir, input logic [7:0] data);
        return {dir, data};
    endfunction

endpackage

// File: rtl/uart_display_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_display_ctrl_if
// Bundles the feeder's source inputs and display-side outputs.
//   baud_sel  [1:0]  baud-select switches
//   rx_valid/rx_data  1-cycle pulse + received byte
//   tx_valid/tx_data  1-cycle pulse + transmitted byte
//   mode, data_dir, msg[7:0]  toward the display stage
//   overflow          sticky event-drop flag
// master: the side that drives the sources (UART / switches / bench)
// slave : uart_display_ctrl
// -----------------------------------------------------------------------------
interface uart_display_ctrl_if;
    logic [1:0] baud_sel;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       mode;
    logic       data_dir;
    logic [7:0] msg;
    logic       overflow;

    modport master (
        output baud_sel, rx_valid, rx_data, tx_valid, tx_data,
        input  mode, data_dir, msg, overflow
    );

    modport slave (
        input  baud_sel, rx_valid, rx_data, tx_valid, tx_data,
        output mode, data_dir, msg, overflow
    );
endinterface

// File: rtl/uart_display_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// disp_event_fifo
// Small event queue with two write ports per cycle (wr0 is stored ahead of wr1)
// and one read port. The caller is responsible for never writing more entries
// than free_cnt (plus a same-cycle read) allows and never reading when empty.
//   src_clk, rst      clock, async active-high reset
//   wr0_en/wr0_d      first entry written this cycle
//   wr1_en/wr1_d      second entry written this cycle (lands after wr0)
//   rd_en             pop the head; rd_d always shows the head
//   empty             no entries stored
//   free_cnt          DEPTH - stored entries
// -----------------------------------------------------------------------------
module disp_event_fifo
    import uart_display_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               src_clk,
    input  logic               rst,
    input  logic               wr0_en,
    input  logic [EVENT_W-1:0] wr0_d,
    input  logic               wr1_en,
    input  logic [EVENT_W-1:0] wr1_d,
    input  logic               rd_en,
    output logic [EVENT_W-1:0] rd_d,
    output logic               empty,
    output logic [CNT_W-1:0]   free_cnt
);

    logic [EVENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr1_ptr_s;
    logic [CNT_W-1:0]   n_push_s;

    // wr1 goes right behind wr0 when both write; pointer math wraps naturally (DEPTH is 2^n)
    always_comb begin
        wr1_ptr_s = wr_ptr_r + PTR_W'(wr0_en);
        n_push_s  = CNT_W'(wr0_en) + CNT_W'(wr1_en);
    end

    // Storage, pointers and occupancy
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (wr0_en) begin
                mem_r[wr_ptr_r] <= wr0_d;
            end
            if (wr1_en) begin
                mem_r[wr1_ptr_s] <= wr1_d;
            end
            wr_ptr_r <= wr_ptr_r + PTR_W'(n_push_s);
            rd_ptr_r <= rd_ptr_r + PTR_W'(rd_en);
            count_r  <= count_r + n_push_s - CNT_W'(rd_en);
        end
    end

    assign rd_d     = mem_r[rd_ptr_r];
    assign empty    = (count_r == CNT_W'(0));
    assign free_cnt = CNT_W'(DEPTH) - count_r;

endmodule

// File: rtl/uart_display_ctrl.sv
// -----------------------------------------------------------------------------
// uart_display_ctrl
// Feeds the 6-digit display stage. Shows the baud code after every switch
// change, otherwise shows queued RX/TX bytes, each for a minimum hold time.
//   src_clk   system clock (rising edge)
//   rst       asynchronous active-high reset
//   bus       uart_display_ctrl_if.slave: baud_sel, rx/tx byte events in;
//             mode, data_dir, msg, overflow out (all registered)
// -----------------------------------------------------------------------------
module uart_display_ctrl
    import uart_display_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int DATA_HOLD_CYC = 50000000,
    parameter int BAUD_HOLD_CYC = 50000000
) (
    input  logic                src_clk,
    input  logic                rst,
    uart_display_ctrl_if.slave  bus
);

    localparam int          CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [31:0] DATA_RELOAD = 32'(DATA_HOLD_CYC - 1);
    localparam logic [31:0] BAUD_RELOAD = 32'(BAUD_HOLD_CYC - 1);

    disp_state_e        state_r, state_s;
    logic [31:0]        hold_cnt_r, hold_cnt_s;
    logic [1:0]         baud_sel_q_r;
    logic               show_dir_r, show_dir_s;
    logic [7:0]         show_byte_r, show_byte_s;
    logic               mode_r, mode_s;
    logic               data_dir_r, data_dir_s;
    logic [7:0]         msg_r, msg_s;
    logic               overflow_r, overflow_s;

    logic               chg_s;
    logic               pop_s;
    logic [CNT_W-1:0]   free_s;
    logic               drop_s;
    logic               wr0_en_s, wr1_en_s;
    logic [EVENT_W-1:0] wr0_d_s, wr1_d_s;
    logic [EVENT_W-1:0] rd_d_s;
    logic               empty_s;
    logic [CNT_W-1:0]   free_cnt_s;

    disp_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .src_clk  (src_clk),
        .rst      (rst),
        .wr0_en   (wr0_en_s),
        .wr0_d    (wr0_d_s),
        .wr1_en   (wr1_en_s),
        .wr1_d    (wr1_d_s),
        .rd_en    (pop_s),
        .rd_d     (rd_d_s),
        .empty    (empty_s),
        .free_cnt (free_cnt_s)
    );

    assign chg_s = (bus.baud_sel != baud_sel_q_r);

    // Next state, hold counter and show registers; a baud change overrides everything
    always_comb begin
        state_s     = state_r;
        hold_cnt_s  = hold_cnt_r;
        show_dir_s  = show_dir_r;
        show_byte_s = show_byte_r;
        pop_s       = 1'b0;
        if (chg_s) begin
            // Queue is left intact; any pop this cycle is simply not issued
            state_s    = S_BAUD;
            hold_cnt_s = BAUD_RELOAD;
        end else begin
            case (state_r)
                S_BAUD, S_DATA: begin
                    if (hold_cnt_r != 32'd0) begin
                        hold_cnt_s = hold_cnt_r - 32'd1;
                    end else if (!empty_s) begin
                        state_s = S_LOAD;
                    end else begin
                        state_s = state_r;
                    end
                end
                S_LOAD: begin
                    pop_s       = 1'b1;
                    show_dir_s  = rd_d_s[8];
                    show_byte_s = rd_d_s[7:0];
                    hold_cnt_s  = DATA_RELOAD;
                    state_s     = S_DATA;
                end
                default: begin
                    state_s    = S_BAUD;
                    hold_cnt_s = 32'd0;
                end
            endcase
        end
    end

    // Output values follow the next state so the registered outputs line up with it;
    // the load cycle keeps whatever was on display
    always_comb begin
        mode_s     = mode_r;
        data_dir_s = data_dir_r;
        msg_s      = msg_r;
        case (state_s)
            S_BAUD: begin
                mode_s = BAUDRATE_MODE;
                msg_s  = {6'b000000, bus.baud_sel};
            end
            S_DATA: begin
                mode_s     = DATA_MODE;
                data_dir_s = show_dir_s;
                msg_s      = show_byte_s;
            end
            S_LOAD: begin
                mode_s     = mode_r;
                data_dir_s = data_dir_r;
                msg_s      = msg_r;
            end
            default: begin
                mode_s     = BAUDRATE_MODE;
                data_dir_s = DIR_RX;
                msg_s      = 8'h00;
            end
        endcase
    end

    // Push arbitration: free slots count this cycle's pop; RX always wins the last slot
    always_comb begin
        free_s   = free_cnt_s + CNT_W'(pop_s);
        wr0_en_s = 1'b0;
        wr0_d_s  = pack_event(DIR_RX, bus.rx_data);
        wr1_en_s = 1'b0;
        wr1_d_s  = pack_event(DIR_TX, bus.tx_data);
        drop_s   = 1'b0;
        if (bus.rx_valid && bus.tx_valid) begin
            if (free_s >= CNT_W'(2)) begin
                wr0_en_s = 1'b1;
                wr1_en_s = 1'b1;
            end else if (free_s != CNT_W'(0)) begin
                wr0_en_s = 1'b1;
                drop_s   = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else if (bus.rx_valid || bus.tx_valid) begin
            wr0_d_s = bus.rx_valid ? pack_event(DIR_RX, bus.rx_data)
                                   : pack_event(DIR_TX, bus.tx_data);
            if (free_s != CNT_W'(0)) begin
                wr0_en_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = 1'b0;
        end
        overflow_s = overflow_r | drop_s;
    end

    // State, counter, show and output registers
    always_ff @(posedge src_clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_BAUD;
            hold_cnt_r   <= 32'd0;
            baud_sel_q_r <= SEL_9600;
            show_dir_r   <= DIR_RX;
            show_byte_r  <= 8'h00;
            mode_r       <= BAUDRATE_MODE;
            data_dir_r   <= DIR_RX;
            msg_r        <= 8'h00;
            overflow_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            hold_cnt_r   <= hold_cnt_s;
            baud_sel_q_r <= bus.baud_sel;
            show_dir_r   <= show_dir_s;
            show_byte_r  <= show_byte_s;
            mode_r       <= mode_s;
            data_dir_r   <= data_dir_s;
            msg_r        <= msg_s;
            overflow_r   <= overflow_s;
        end
    end

    assign bus.mode     = mode_r;
    assign bus.data_dir = data_dir_r;
    assign bus.msg      = msg_r;
    assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_uart_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_display_ctrl
// Scenario tasks for the UART display feeder with FIFO_DEPTH=4, DATA_HOLD_CYC=4,
// BAUD_HOLD_CYC=3. Expected values come from the display timing rules: a byte
// accepted while idle shows two edges later, each queued byte is on screen for
// DATA_HOLD+1 samples (hold plus load cycle), a baud change shows one edge later.
// -----------------------------------------------------------------------------
module tb_uart_display_ctrl;
    import uart_display_ctrl_pkg::*;

    localparam int DEPTH = 4;
    localparam int DHOLD = 4;
    localparam int BHOLD = 3;

    logic src_clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    uart_display_ctrl_if bus_if();

    uart_display_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .DATA_HOLD_CYC (DHOLD),
        .BAUD_HOLD_CYC (BHOLD)
    ) dut (
        .src_clk (src_clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 src_clk = ~src_clk;

    task automatic tick;
        @(posedge src_clk);
        #1;
    endtask

    task automatic clear_events;
        bus_if.rx_valid = 1'b0;
        bus_if.tx_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus_if.baud_sel = SEL_9600;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_data  = 8'h00;
        clear_events();
        repeat (2) tick();
        tests_run++;
        if ({bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow} !== {BAUDRATE_MODE, DIR_RX, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset_state: got %b/%b/%h/%b want 0/0/00/0",
                     bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({bus_if.mode, bus_if.msg} !== {BAUDRATE_MODE, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_release: got %b/%h want 0/00", bus_if.mode, bus_if.msg);
        end
    endtask

    task automatic test_baud_show;
        bus_if.baud_sel = SEL_115200;
        for (int i = 0; i <= BHOLD; i++) begin
            tick();
            tests_run++;
            if ({bus_if.mode, bus_if.msg} !== {BAUDRATE_MODE, 8'h02}) begin
                tests_failed++;
                $display("FAIL baud_115200 cyc%0d: got %b/%h want 0/02", i, bus_if.mode, bus_if.msg);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_idle_rx;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h41;
        tick();
        clear_events();
        for (int j = 0; j < 2; j++) begin
            tests_run++;
            if (bus_if.mode !== BAUDRATE_MODE) begin
                tests_failed++;
                $display("FAIL idle_rx_latency k+%0d: mode %b want 0", j, bus_if.mode);
            end
            tick();
        end
        for (int j = 0; j < 12; j++) begin
            tests_run++;
            if ({bus_if.mode, bus_if.data_dir, bus_if.msg} !== {DATA_MODE, DIR_RX, 8'h41}) begin
                tests_failed++;
                $display("FAIL idle_rx_show k+%0d: got %b/%b/%h want 1/0/41",
                         j + 2, bus_if.mode, bus_if.data_dir, bus_if.msg);
            end
            tick();
        end
    endtask

    task automatic test_rx_tx_pair;
        logic [9:0] exp_v;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h31;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h32;
        tick();
        clear_events();
        // k and k+1 still show 0x41; 0x31 for DHOLD+1 samples; then 0x32 for good
        for (int j = 0; j < 2 + (DHOLD + 1) + 6; j++) begin
            if (j < 2)
                exp_v = {DATA_MODE, DIR_RX, 8'h41};
            else if (j < 2 + DHOLD + 1)
                exp_v = {DATA_MODE, DIR_RX, 8'h31};
            else
                exp_v = {DATA_MODE, DIR_TX, 8'h32};
            tests_run++;
            if ({bus_if.mode, bus_if.data_dir, bus_if.msg} !== exp_v) begin
                tests_failed++;
                $display("FAIL rx_tx_pair k+%0d: got %b/%b/%h want %b/%b/%h", j,
                         bus_if.mode, bus_if.data_dir, bus_if.msg, exp_v[9], exp_v[8], exp_v[7:0]);
            end
            tick();
        end
    endtask

    task automatic test_overflow;
        logic [7:0] b;
        // baud_sel toggles every cycle so the hold never expires and nothing pops
        for (int i = 0; i < 6; i++) begin
            bus_if.baud_sel = (i % 2 == 0) ? SEL_57600 : SEL_115200;
            bus_if.rx_valid = 1'b1;
            bus_if.rx_data  = 8'(8'h30 + i);
            tick();
            tests_run++;
            if ({bus_if.mode, bus_if.msg, bus_if.overflow} !== {BAUDRATE_MODE, 6'b000000, bus_if.baud_sel, (i >= 4)}) begin
                tests_failed++;
                $display("FAIL overflow_burst i%0d: got %b/%h/%b want 0/%h/%b", i,
                         bus_if.mode, bus_if.msg, bus_if.overflow, bus_if.baud_sel, (i >= 4));
            end
        end
        clear_events();
        for (int s = 0; s < BHOLD; s++) begin
            tick();
            tests_run++;
            if ({bus_if.mode, bus_if.msg} !== {BAUDRATE_MODE, 8'h02}) begin
                tests_failed++;
                $display("FAIL overflow_baud_hold s%0d: got %b/%h want 0/02", s, bus_if.mode, bus_if.msg);
            end
        end
        for (int e = 0; e < 4; e++) begin
            b = 8'(8'h30 + e);
            for (int s = 0; s < DHOLD + 1 + ((e == 3) ? 8 : 0); s++) begin
                tick();
                tests_run++;
                if ({bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow} !== {DATA_MODE, DIR_RX, b, 1'b1}) begin
                    tests_failed++;
                    $display("FAIL overflow_drain e%0d s%0d: got %b/%b/%h/%b want 1/0/%h/1", e, s,
                             bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow, b);
                end
            end
        end
    endtask

    task automatic test_baud_interrupt;
        logic [9:0] exp_v;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h41;
        tick();
        clear_events();
        repeat (2) tick();
        tests_run++;
        if ({bus_if.mode, bus_if.data_dir, bus_if.msg} !== {DATA_MODE, DIR_RX, 8'h41}) begin
            tests_failed++;
            $display("FAIL interrupt_setup: got %b/%b/%h want 1/0/41", bus_if.mode, bus_if.data_dir, bus_if.msg);
        end
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h42;
        bus_if.tx_valid = 1'b1;
        bus_if.tx_data  = 8'h43;
        tick();
        clear_events();
        bus_if.baud_sel = SEL_9600;
        for (int j = 0; j < (BHOLD + 1) + (DHOLD + 1) + 4; j++) begin
            tick();
            if (j < BHOLD + 1) begin
                tests_run++;
                if ({bus_if.mode, bus_if.msg} !== {BAUDRATE_MODE, 8'h00}) begin
                    tests_failed++;
                    $display("FAIL interrupt_baud j%0d: got %b/%h want 0/00", j, bus_if.mode, bus_if.msg);
                end
            end else begin
                exp_v = (j < BHOLD + 1 + DHOLD + 1) ? {DATA_MODE, DIR_RX, 8'h42} : {DATA_MODE, DIR_TX, 8'h43};
                tests_run++;
                if ({bus_if.mode, bus_if.data_dir, bus_if.msg} !== exp_v) begin
                    tests_failed++;
                    $display("FAIL interrupt_queue j%0d: got %b/%b/%h want %b/%b/%h", j,
                             bus_if.mode, bus_if.data_dir, bus_if.msg, exp_v[9], exp_v[8], exp_v[7:0]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        // Queue a byte, then reset before it can show: it must never appear
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h55;
        tick();
        clear_events();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if ({bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow} !== {BAUDRATE_MODE, DIR_RX, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: got %b/%b/%h/%b want 0/0/00/0",
                     bus_if.mode, bus_if.data_dir, bus_if.msg, bus_if.overflow);
        end
        #1;
        rst = 1'b0;
        for (int j = 0; j < 6; j++) begin
            tick();
            tests_run++;
            if ({bus_if.mode, bus_if.msg, bus_if.overflow} !== {BAUDRATE_MODE, 8'h00, 1'b0}) begin
                tests_failed++;
                $display("FAIL async_reset_flush j%0d: got %b/%h/%b want 0/00/0",
                         j, bus_if.mode, bus_if.msg, bus_if.overflow);
            end
        end
    endtask

    task automatic test_random_baud;
        logic [1:0] cur = SEL_9600;
        logic [1:0] nxt;
        for (int i = 0; i < 8; i++) begin
            do nxt = 2'($urandom_range(0, 3)); while (nxt == cur);
            bus_if.baud_sel = nxt;
            for (int s = 0; s < 2; s++) begin
                tick();
                tests_run++;
                if ({bus_if.mode, bus_if.msg} !== {BAUDRATE_MODE, 6'b000000, nxt}) begin
                    tests_failed++;
                    $display("FAIL random_baud i%0d s%0d: got %b/%h want 0/%h", i, s, bus_if.mode, bus_if.msg, nxt);
                end
            end
            cur = nxt;
        end
        repeat (BHOLD + 2) tick();
    endtask

    task automatic test_random_events;
        logic [8:0] exp_q[$];
        logic [8:0] ev;
        int         ncyc, kind, total, e, j;
        for (int burst = 0; burst < 8; burst++) begin
            exp_q.delete();
            ncyc = $urandom_range(1, 2);
            j = -1;
            for (int c = 0; c < ncyc; c++) begin
                kind = $urandom_range(0, 2);
                bus_if.rx_data  = 8'($urandom_range(0, 255));
                bus_if.tx_data  = 8'($urandom_range(0, 255));
                bus_if.rx_valid = (kind != 1);
                bus_if.tx_valid = (kind != 0);
                if (kind != 1) exp_q.push_back({DIR_RX, bus_if.rx_data});
                if (kind != 0) exp_q.push_back({DIR_TX, bus_if.tx_data});
                tick();
                j++;
            end
            clear_events();
            total = 2 + exp_q.size() * (DHOLD + 1) + 2;
            while (j < total) begin
                tick();
                j++;
                if (j >= 2) begin
                    e = (j - 2) / (DHOLD + 1);
                    if (e >= exp_q.size()) e = exp_q.size() - 1;
                    ev = exp_q[e];
                    tests_run++;
                    if ({bus_if.mode, bus_if.data_dir, bus_if.msg} !== {DATA_MODE, ev}) begin
                        tests_failed++;
                        $display("FAIL random_events b%0d k+%0d: got %b/%b/%h want 1/%b/%h", burst, j,
                                 bus_if.mode, bus_if.data_dir, bus_if.msg, ev[8], ev[7:0]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_baud_show();
        test_idle_rx();
        test_rx_tx_pair();
        test_overflow();
        test_baud_interrupt();
        test_async_reset();
        test_random_baud();
        test_random_events();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
